// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: one register stage per shift-amount bit,
// four modes (ROL, ROR, SLL, SRA) and a single global stall on back-pressure.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;

  logic adv;

  logic             stg_valid [SHW];
  logic [WIDTH-1:0] stg_data  [SHW];
  logic [1:0]       stg_mode  [SHW];
  logic [SHW-1:0]   stg_shift [SHW];
  logic             stg_sign  [SHW];

  logic             nxt_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [1:0]       src_mode  [SHW];
  logic [SHW-1:0]   src_shift [SHW];
  logic             src_sign  [SHW];

  // Single shift by a fixed power-of-two amount; SRA fills with the carried sign.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input logic sign,
                                                  input int amt);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    case (mode)
      MODE_ROL: res = (d << amt) | (d >> (WIDTH - amt));
      MODE_ROR: res = (d >> amt) | (d << (WIDTH - amt));
      MODE_SLL: res = d << amt;
      default:  res = (d >> amt) | fill;
    endcase
    return res;
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 0 draws from the input port; every later stage from its predecessor.
  for (genvar k = 0; k < SHW; k++) begin : gen_src
    if (k == 0) begin : gen_head
      assign nxt_valid[k] = in_valid;
      assign src_data[k]  = in_data;
      assign src_mode[k]  = in_mode;
      assign src_shift[k] = in_shift;
      assign src_sign[k]  = in_data[WIDTH-1];
    end else begin : gen_body
      assign nxt_valid[k] = stg_valid[k-1];
      assign src_data[k]  = stg_data[k-1];
      assign src_mode[k]  = stg_mode[k-1];
      assign src_shift[k] = stg_shift[k-1];
      assign src_sign[k]  = stg_sign[k-1];
    end
  end

  // Payload registers only load behind a valid beat, so the output keeps the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        stg_valid[k] <= 1'b0;
        stg_data[k]  <= '0;
        stg_mode[k]  <= '0;
        stg_shift[k] <= '0;
        stg_sign[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < SHW; k++) begin
        stg_valid[k] <= nxt_valid[k];
        if (nxt_valid[k]) begin
          stg_data[k]  <= src_shift[k][k]
                          ? shift_step(src_data[k], src_mode[k], src_sign[k], 2 ** k)
                          : src_data[k];
          stg_mode[k]  <= src_mode[k];
          stg_shift[k] <= src_shift[k];
          stg_sign[k]  <= src_sign[k];
        end
      end
    end
  end

  assign out_valid = stg_valid[SHW-1];
  assign out_data  = stg_data[SHW-1];
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomized self-checking bench for pipelined_barrel_shifter, compared against
// an arithmetic reference model and a queue-based in-order scoreboard.
module tb_pipelined_barrel_shifter;

  localparam int W   = 32;
  localparam int LAT = 5;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shift;
  logic [1:0]  in_mode;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_shift8;
  logic [1:0]  in_mode8;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepted = 0;
  bit          chkLatency = 1'b0;
  bit          expectReadyHigh = 1'b0;
  bit          holdPending = 1'b0;
  logic [31:0] heldData;
  exp_t        sbq[$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_shift(in_shift8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_zero(out_zero8)
  );

  // Reference: rotate/shift of a w-bit value with plain 64-bit arithmetic.
  function automatic logic [31:0] refShift(input logic [31:0] d, input int s,
                                           input logic [1:0] m, input int w);
    logic [63:0] mask, dd, r;
    mask = (64'd1 << w) - 64'd1;
    dd   = {32'd0, d} & mask;
    case (m)
      2'd0:    r = (dd << s) | (dd >> (w - s));
      2'd1:    r = (dd >> s) | (dd << (w - s));
      2'd2:    r = dd << s;
      default: begin
        r = dd >> s;
        if (dd[w-1]) r = r | (mask & ~(mask >> s));
      end
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of the 32-bit DUT, scoreboards the handshake, then steps past the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input int s,
                               input logic [1:0] m, input logic rdy,
                               input bit hasExp = 1'b0, input logic [31:0] expVal = 32'd0);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    in_shift  = s[4:0];
    in_mode   = m;
    out_ready = rdy;
    #1;
    if (expectReadyHigh) checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
    if (holdPending) begin
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_data", out_data, heldData);
    end
    if (out_valid) checkOutput("ready_vs_out_ready", {31'd0, in_ready}, {31'd0, out_ready});
    holdPending = out_valid && !out_ready;
    heldData    = out_data;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_zero", {31'd0, out_zero}, {31'd0, e.data == 32'd0});
        if (chkLatency) checkOutput("latency", cyc - e.cyc, LAT);
      end
    end
    if (in_valid && in_ready) begin
      e.data = hasExp ? expVal : refShift(d, s, m, W);
      e.cyc  = cyc;
      sbq.push_back(e);
      accepted++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drainQueue(input int budget, input bit randomReady);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      applyStimulus(1'b0, 32'd0, 0, 2'd0, randomReady ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    checkOutput("drain_left", sbq.size(), 32'd0);
    while (out_valid && n < budget + 20) begin
      applyStimulus(1'b0, 32'd0, 0, 2'd0, 1'b1);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] d;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_shift8 = '0; in_mode8 = '0; out_ready8 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_zero", {31'd0, out_zero}, 32'd1);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'd0, 0, 2'd0, 1'b1);
      checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
    end
    checkOutput("idle_out_data", out_data, 32'd0);
    checkOutput("idle_out_zero", {31'd0, out_zero}, 32'd1);

    chkLatency = 1'b1;
    applyStimulus(1'b1, 32'h8000_0001, 4, 2'd0, 1'b1, 1'b1, 32'h0000_0018);
    applyStimulus(1'b1, 32'h8000_0001, 4, 2'd1, 1'b1, 1'b1, 32'h1800_0000);
    applyStimulus(1'b1, 32'h8000_0001, 4, 2'd2, 1'b1, 1'b1, 32'h0000_0010);
    applyStimulus(1'b1, 32'h8000_0001, 4, 2'd3, 1'b1, 1'b1, 32'hF800_0000);
    drainQueue(30, 1'b0);

    for (int m = 0; m < 4; m++)
      applyStimulus(1'b1, 32'hDEAD_BEEF, 0, 2'(m), 1'b1, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 31, 2'd2, 1'b1, 1'b1, 32'h8000_0000);
    applyStimulus(1'b1, 32'h8000_0000, 31, 2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'h8000_0000, 1, 2'd2, 1'b1, 1'b1, 32'h0000_0000);
    drainQueue(30, 1'b0);

    expectReadyHigh = 1'b1;
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b1, $urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 1'b1);
    expectReadyHigh = 1'b0;
    drainQueue(30, 1'b0);

    chkLatency = 1'b0;
    accepted = 0;
    n = 0;
    while (accepted < 10 && n < 300) begin
      d = $urandom;
      applyStimulus(1'b1, d, $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
      n++;
    end
    checkOutput("bp_accepted", accepted, 32'd10);
    drainQueue(300, 1'b1);

    chkLatency = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, $urandom, $urandom_range(1, 31), 2'($urandom_range(0, 3)), 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    holdPending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'd0, 0, 2'd0, 1'b1);
      checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(1'b1, 32'h1234_5678, 12, 2'd1, 1'b1);
    drainQueue(30, 1'b0);

    for (int i = 0; i < 3; i++) begin
      in_valid8 = 1'b1;
      in_data8  = 8'($urandom);
      in_shift8 = 3'($urandom_range(1, 7));
      in_mode8  = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("w8_rst_valid", {31'd0, out_valid8}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("w8_post_rst_valid", {31'd0, out_valid8}, 32'd0);
    end
    in_valid8 = 1'b1;
    in_data8  = 8'h96;
    in_shift8 = 3'd3;
    in_mode8  = 2'd3;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("w8_latency", n, 32'd3);
    checkOutput("w8_data", {24'd0, out_data8}, 32'h0000_00F2);
    checkOutput("w8_model", {24'd0, out_data8}, refShift(32'h96, 3, 2'd3, 8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter. Successor to the combinational 32-bit left rotator.
- Adds configurable data width and four shift modes: rotate left, rotate right, logical left, arithmetic right.
- Uses one register stage per log2 shift stage, with a valid/ready stream handshake and global back-pressure stall.
- Sits in the datapath between operand staging and the ALU result mux.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two and at least 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth. Derived only; never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  WIDTH  operand
- in_shift  input  SHW  shift amount, 0..WIDTH-1
- in_mode  input  2  00 ROL, 01 ROR, 10 SLL, 11 SRA
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data equals 0

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits, data, mode and residual-shift registers clear to 0. Outputs during and after reset: out_valid=0, out_data=0, out_zero=1, in_ready=1.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Accept: a beat is accepted when in_valid && in_ready.
- Pipeline:
  - When adv=1, all SHW stages shift forward together.
  - When adv=0, every stage holds its contents and valid bit unchanged.
  - Bubbles are not collapsed.
- Stage k (k=0..SHW-1) processes shift bit k. It shifts by 2^k if that bit is set, otherwise passes data through. Each stage carries the mode and remaining shift bits forward with the data.
- Mode rules:
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - SLL: vacated LSBs filled with 0.
  - SRA: vacated MSBs filled with the original operand's MSB. The sign bit is captured at stage 0 and carried down the pipeline.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+SHW-1, i.e. SHW register stages. Example: 5 for WIDTH=32, 2 for WIDTH=4.
- Throughput: one beat per cycle while out_ready stays high.
- out_zero: combinational from out_data.
- Shift amount 0 in any mode: out_data = in_data.
- Back-pressure: out_valid && !out_ready holds out_data stable and drops in_ready in the same cycle. No beat is lost or duplicated.
- Simultaneous accept and emit (adv=1, in_valid=1, out_valid=1, out_ready=1): both occur in the same edge.
- in_valid low when adv=1: a bubble (valid=0) enters stage 0.
- Reset mid-stream: all in-flight beats are discarded. No output beat is emitted after reset release until a new beat has been accepted and traversed the pipeline.
- The output data register always holds the last computed value. Downstream samples only when out_valid=1.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles, then release → out_valid=0, out_data=0, out_zero=1, in_ready=1; no spurious out_valid for 10 cycles with in_valid=0.
- Mode sweep (WIDTH=32), in_data=0x8000_0001, in_shift=4, out_ready=1, one beat per mode → ROL 0x0000_0018; ROR 0x1800_0000; SLL 0x0000_0010; SRA 0xF800_0000. Each appears exactly 5 cycles after acceptance.
- Streaming: 64 back-to-back random beats with out_ready=1 → in_ready constantly 1; results match the reference model in order, one per cycle, with latency 5.
- Back-pressure: stream 10 beats and toggle out_ready pseudo-randomly (~50%) → out_data stable while out_valid && !out_ready; in_ready==out_ready whenever out_valid; all 10 results delivered, in order, no duplicates.
- Edge cases: in_shift=0 with in_data=0xDEAD_BEEF in all modes → 0xDEAD_BEEF; SLL by 31 of 0xFFFF_FFFF → 0x8000_0000; SRA by 31 of 0x8000_0000 → 0xFFFF_FFFF; SLL by 1 of 0x8000_0000 → 0, out_zero=1.
- Reset mid-stream: with 3 beats in flight, assert rst_n for 1 cycle → out_valid=0 immediately and stays 0. A new beat accepted after release emerges 5 cycles later with the correct value. Repeat with WIDTH=8 to confirm latency 3.
